// File: rtl/dma_xfer_ctrl_pkg.sv
// Shared DMA definitions: FSM state encoding and default bus/timeout sizes.
package dma_xfer_ctrl_pkg;

  localparam int DMA_AW_DEF         = 8;
  localparam int DMA_DW_DEF         = 8;
  localparam int DMA_RD_TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } dma_state_e;

endpackage

// File: rtl/dma_xfer_counter.sv
// Source/destination pointers and remaining byte count; load on start, step after each write.
// Pointers wrap modulo 2^AW; last_o flags the final byte of the block.
module dma_xfer_counter
  import dma_xfer_ctrl_pkg::*;
#(
  parameter int AW = DMA_AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  input  logic [7:0]    cnt_i,
  output logic [AW-1:0] src_cur_o,
  output logic [AW-1:0] dst_cur_o,
  output logic          last_o
);

  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [7:0]    rem_q, rem_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    if (load_i) begin
      src_d = src_i;
      dst_d = dst_i;
      rem_d = cnt_i;
    end else if (step_i) begin
      src_d = src_q + AW'(1);
      dst_d = dst_q + AW'(1);
      rem_d = rem_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
    end
  end

  assign src_cur_o = src_q;
  assign dst_cur_o = dst_q;
  assign last_o    = (rem_q == 8'd1);

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Memory-to-memory DMA: per byte RD_REQ, RD_WAIT until DB_wrReq, WR; 3N+1 cycles minimum.
// Stalls in RD_WAIT on a slow memory; DMA_TIMEOUT_EN adds a read timeout that aborts via ERR.
module dma_xfer_ctrl
  import dma_xfer_ctrl_pkg::*;
#(
  parameter int AW = DMA_AW_DEF,
  parameter int DW = DMA_DW_DEF
`ifdef DMA_TIMEOUT_EN
  ,
  parameter int RD_TIMEOUT = DMA_RD_TIMEOUT_DEF
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [7:0]    count,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] Address,
  output logic          MemRead,
  output logic          Enable,
  output logic          DB_tri,
  inout  wire  [DW-1:0] DB_io,
  input  logic          DB_wrReq
);

  dma_state_e    state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] addr_q;
  logic          cnt_load, cnt_step, cnt_last;
  logic [AW-1:0] src_cur, dst_cur;

  dma_xfer_counter #(
    .AW (AW)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .step_i    (cnt_step),
    .src_i     (src_addr),
    .dst_i     (dst_addr),
    .cnt_i     (count),
    .src_cur_o (src_cur),
    .dst_cur_o (dst_cur),
    .last_o    (cnt_last)
  );

`ifdef DMA_TIMEOUT_EN
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout;

  // Timer restarts from zero on every entry into RD_WAIT.
  assign timer_d = (state_q == ST_RD_WAIT) ? timer_q + TW'(1) : '0;
  assign timeout = (timer_q == TW'(RD_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    Enable   = 1'b0;
    MemRead  = 1'b0;
    DB_tri   = 1'b0;
    Address  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count != 8'd0) begin
            cnt_load = 1'b1;
            state_d  = ST_RD_REQ;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_RD_REQ: begin
        busy    = 1'b1;
        Enable  = 1'b1;
        MemRead = 1'b1;
        Address = src_cur;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        busy    = 1'b1;
        Enable  = 1'b1;
        MemRead = 1'b1;
        Address = src_cur;
        if (DB_wrReq) begin
          data_d  = DB_io;
          state_d = ST_WR;
        end
`ifdef DMA_TIMEOUT_EN
        else if (timeout) begin
          state_d = ST_ERR;
        end
`endif
      end
      ST_WR: begin
        busy     = 1'b1;
        Enable   = 1'b1;
        DB_tri   = 1'b1;
        Address  = dst_cur;
        cnt_step = 1'b1;
        state_d  = cnt_last ? ST_DONE : ST_RD_REQ;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
`ifdef DMA_TIMEOUT_EN
        error   = 1'b1;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address register lets IDLE/DONE/ERR hold the last presented address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= Address;
    end
  end

  assign DB_io = DB_tri ? data_q : {DW{1'bz}};

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed bench for dma_xfer_ctrl with a memory responder and read/write scoreboard queues.
module tb_dma_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] src_addr = 8'd0;
  logic [7:0] dst_addr = 8'd0;
  logic [7:0] count = 8'd0;
  logic       DB_wrReq = 1'b0;
  wire        busy, done, error, MemRead, Enable, DB_tri;
  wire  [7:0] Address;
  wire  [7:0] DB_io;

  logic       drv_en = 1'b0;
  logic [7:0] drv_dat = 8'd0;
  logic       probe_en = 1'b0;
  logic [7:0] probe_dat = 8'd0;

  assign DB_io = drv_en ? drv_dat : (probe_en ? probe_dat : 8'hzz);

  always #5 clk = ~clk;

  dma_xfer_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .Address  (Address),
    .MemRead  (MemRead),
    .Enable   (Enable),
    .DB_tri   (DB_tri),
    .DB_io    (DB_io),
    .DB_wrReq (DB_wrReq)
  );

  int          total = 0;
  int          bad = 0;
  logic [7:0]  mem [256];
  int          rd_delay = 0;
  bit          mem_en = 1'b1;
  logic [7:0]  exp_rd [$];
  logic [15:0] exp_wr [$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          en_cnt = 0;
  bit          rd_prev = 1'b0;
  int          rd_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: answers a read rd_delay cycles into RD_WAIT, drives for one cycle.
  always begin
    @(negedge clk);
    if (Enable && MemRead) begin
      if (mem_en && rd_cyc == rd_delay + 1) begin
        DB_wrReq = 1'b1;
        drv_en   = 1'b1;
        drv_dat  = mem[Address];
        @(posedge clk);
        #1;
        DB_wrReq = 1'b0;
        drv_en   = 1'b0;
      end
      rd_cyc++;
    end else begin
      rd_cyc = 0;
    end
  end

  // Scoreboard: each read request and each write cycle is matched against the queues.
  always @(negedge clk) begin
    logic [15:0] e;
    if (done)   done_cnt++;
    if (error)  err_cnt++;
    if (Enable) en_cnt++;
    if (Enable && MemRead && !rd_prev) begin
      check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) check("rd_addr", Address, exp_rd.pop_front());
    end
    rd_prev = Enable && MemRead;
    if (Enable && !MemRead) begin
      check("wr_dbtri", DB_tri, 1);
      check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        e = exp_wr.pop_front();
        check("wr_addr", Address, e[15:8]);
        check("wr_data", DB_io, e[7:0]);
      end
    end else begin
      check("dbtri_off", DB_tri, 0);
    end
  end

  task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] c,
                          input int max, input int poke, input bit exp_wrs,
                          input bit start_at_done, output int cyc, output int gaps);
    logic [7:0] a;
    for (int i = 0; i < int'(c); i++) begin
      a = s + 8'(i);
      exp_rd.push_back(a);
      if (exp_wrs) exp_wr.push_back({d + 8'(i), mem[a]});
    end
    @(negedge clk);
    src_addr = s; dst_addr = d; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    gaps = 0;
    while (!done && !error && cyc < max) begin
      if (!busy) gaps++;
      start = (cyc == poke);
      if (cyc == poke) begin
        src_addr = 8'h77; dst_addr = 8'h88; count = 8'd1;
      end
      @(negedge clk);
      cyc++;
    end
    start = start_at_done;
    if (start_at_done) begin
      src_addr = 8'h11; dst_addr = 8'h12; count = 8'd1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int cyc, gaps, d0, e0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[100] = 8'h5A;
    mem[10] = 8'hC1; mem[11] = 8'hC2; mem[12] = 8'hC3; mem[13] = 8'hC4;
    mem[8'hFE] = 8'hE1; mem[8'hFF] = 8'hE2; mem[0] = 8'hE3;
    mem[8'h60] = 8'hB1; mem[8'h61] = 8'hB2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_enable", Enable, 0);
    check("rst_memread", MemRead, 0);
    check("rst_addr", Address, 0);
    probe_en = 1'b1; probe_dat = 8'h3C;
    #1;
    check("rst_bus_released", DB_io, 8'h3C);
    probe_en = 1'b0;
    rst = 1'b0;

    // single byte
    rd_delay = 0; d0 = done_cnt;
    run_xfer(8'd100, 8'd200, 8'd1, 50, 0, 1'b1, 1'b0, cyc, gaps);
    check("t1_latency", cyc, 4);
    check("t1_done_width", done, 0);
    check("t1_busy_after", busy, 0);
    check("t1_done_cnt", done_cnt, d0 + 1);
    check("t1_q_empty", exp_rd.size() + exp_wr.size(), 0);
    check("t1_addr_hold", Address, 200);

    // four bytes, slow memory
    rd_delay = 2; d0 = done_cnt;
    run_xfer(8'd10, 8'd50, 8'd4, 100, 0, 1'b1, 1'b0, cyc, gaps);
    check("t2_latency", cyc, 21);
    check("t2_busy_gaps", gaps, 0);
    check("t2_done_cnt", done_cnt, d0 + 1);
    check("t2_q_empty", exp_rd.size() + exp_wr.size(), 0);

    // address wrap
    rd_delay = 0; d0 = done_cnt;
    run_xfer(8'hFE, 8'hFF, 8'd3, 50, 0, 1'b1, 1'b0, cyc, gaps);
    check("t3_latency", cyc, 10);
    check("t3_q_empty", exp_rd.size() + exp_wr.size(), 0);
    check("t3_addr_hold", Address, 8'h01);

    // empty transfer, plus start presented during DONE
    d0 = done_cnt; e0 = en_cnt;
    run_xfer(8'd5, 8'd6, 8'd0, 20, 0, 1'b1, 1'b1, cyc, gaps);
    check("t4_latency", cyc, 1);
    check("t4_busy_after", busy, 0);
    repeat (4) @(negedge clk);
    check("t4_no_enable", en_cnt, e0);
    check("t4_done_cnt", done_cnt, d0 + 1);

    // start while busy is ignored
    d0 = done_cnt;
    run_xfer(8'h60, 8'h70, 8'd2, 50, 2, 1'b1, 1'b0, cyc, gaps);
    check("t5_latency", cyc, 7);
    repeat (3) @(negedge clk);
    check("t5_idle", busy, 0);
    check("t5_done_cnt", done_cnt, d0 + 1);
    check("t5_q_empty", exp_rd.size() + exp_wr.size(), 0);

    // reset during WR of byte 2 of 4
    d0 = done_cnt;
    for (int i = 0; i < 2; i++) begin
      exp_rd.push_back(8'h20 + 8'(i));
      exp_wr.push_back({8'h40 + 8'(i), mem[8'h20 + i]});
    end
    @(negedge clk);
    src_addr = 8'h20; dst_addr = 8'h40; count = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_in_wr", {Enable, MemRead, DB_tri}, 3'b101);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_outs", {busy, done, error, Enable, MemRead, DB_tri}, 6'b0);
    check("t6_rst_addr", Address, 0);
    probe_en = 1'b1; probe_dat = 8'hA7;
    #1;
    check("t6_bus_released", DB_io, 8'hA7);
    probe_en = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_no_done", done_cnt, d0);
    check("t6_q_empty", exp_rd.size() + exp_wr.size(), 0);
    mem[8'h90] = 8'h6D;
    run_xfer(8'h90, 8'hA0, 8'd1, 50, 0, 1'b1, 1'b0, cyc, gaps);
    check("t6_restart_latency", cyc, 4);
    check("t6_restart_done", done_cnt, d0 + 1);

    // memory never answers
    mem_en = 1'b0; d0 = done_cnt;
`ifdef DMA_TIMEOUT_EN
    run_xfer(8'h30, 8'h31, 8'd1, 60, 0, 1'b0, 1'b0, cyc, gaps);
    check("t7_err_cycle", cyc, 17);
    check("t7_err_width", error, 0);
    check("t7_busy_after", busy, 0);
    check("t7_err_cnt", err_cnt, 1);
`else
    run_xfer(8'h30, 8'h31, 8'd1, 40, 0, 1'b0, 1'b0, cyc, gaps);
    check("t7_still_waiting", cyc, 40);
    check("t7_busy", busy, 1);
    check("t7_rd_wait", {Enable, MemRead}, 2'b11);
    check("t7_err_cnt", err_cnt, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    check("t7_no_done", done_cnt, d0);
    check("t7_q_empty", exp_rd.size() + exp_wr.size(), 0);
    mem_en = 1'b1;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
